// File: rtl/first_nios2_system_sysinfo.sv
// System-identification and uptime peripheral for the Avalon-MM bus.
// It provides fixed ID words, scratch/control/status registers and a free-running uptime counter.
module first_nios2_system_sysinfo #(
  parameter logic [31:0] SYSTEM_ID = 32'h5A7B_0001,
  parameter logic [31:0] TIMESTAMP = 32'd1518032159,
  parameter int          NUM_USER  = 4,
  parameter logic [32*((NUM_USER > 0) ? NUM_USER : 1)-1:0] USER_VALUES = '0,
  parameter int          CNT_W     = 64,
  parameter int          ADDR_W    = 4,
  parameter logic [7:0]  VERSION   = 8'h02
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  generate
    if ((1 << ADDR_W) < (8 + NUM_USER)) begin : g_addr_chk
      $error("ADDR_W too small for 8 + NUM_USER words");
    end
    if (NUM_USER < 0 || NUM_USER > 8) begin : g_user_chk
      $error("NUM_USER must be 0..8");
    end
    if (CNT_W < 33 || CNT_W > 64) begin : g_cnt_chk
      $error("CNT_W must be 33..64");
    end
  endgenerate

  localparam logic [7:0]  NUM_USER_B = 8'(NUM_USER);
  localparam logic [7:0]  ADDR_W_B   = 8'(ADDR_W);
  localparam logic [31:0] PARAM_WORD = {8'h00, NUM_USER_B, ADDR_W_B, VERSION};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_shadow_q, hi_shadow_d;
  logic [31:0]      scratch_q, scratch_d;
  logic             en_q, en_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             readdatavalid_q, readdatavalid_d;

  logic [31:0] rdata_mux;
  logic [31:0] cnt_hi_ext;
  logic        wr_ctrl, wr_stat, clr, inc;

  assign cnt_hi_ext = 32'(cnt_q >> 32);

  always_comb begin
    rdata_mux = '0;
    case (address)
      ADDR_W'(0): rdata_mux = SYSTEM_ID;
      ADDR_W'(1): rdata_mux = TIMESTAMP;
      ADDR_W'(2): rdata_mux = cnt_q[31:0];
      ADDR_W'(3): rdata_mux = hi_shadow_q;
      ADDR_W'(4): rdata_mux = scratch_q;
      ADDR_W'(5): rdata_mux = {31'b0, en_q};
      ADDR_W'(6): rdata_mux = {31'b0, ovf_q};
      ADDR_W'(7): rdata_mux = PARAM_WORD;
      default: begin
        for (int k = 0; k < NUM_USER; k++) begin
          if (address == ADDR_W'(8 + k)) rdata_mux = USER_VALUES[32*k +: 32];
        end
      end
    endcase
  end

  always_comb begin
    wr_ctrl = write && (address == ADDR_W'(5)) && byteenable[0];
    wr_stat = write && (address == ADDR_W'(6)) && byteenable[0];
    clr     = wr_ctrl && writedata[1];
    inc     = en_q && !clr;

    en_d = wr_ctrl ? writedata[0] : en_q;

    // Clear beats increment; the wrap into zero is what flags overflow.
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + CNT_W'(1);

    ovf_d = ovf_q;
    if (inc && (&cnt_q))                ovf_d = 1'b1;
    else if (wr_stat && writedata[0])   ovf_d = 1'b0;

    scratch_d = scratch_q;
    if (write && (address == ADDR_W'(4))) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) scratch_d[8*b +: 8] = writedata[8*b +: 8];
      end
    end

    // Reading the low word captures the high half from the same cycle for a coherent 64-bit sample.
    hi_shadow_d = hi_shadow_q;
    if (read && (address == ADDR_W'(2))) hi_shadow_d = cnt_hi_ext;

    readdata_d      = read ? rdata_mux : readdata_q;
    readdatavalid_d = read;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q           <= '0;
      hi_shadow_q     <= '0;
      scratch_q       <= '0;
      en_q            <= 1'b1;
      ovf_q           <= 1'b0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      hi_shadow_q     <= hi_shadow_d;
      scratch_q       <= scratch_d;
      en_q            <= en_d;
      ovf_q           <= ovf_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;

endmodule

// File: doc/first_nios2_system_sysinfo.md
Name: first_nios2_system_sysinfo

Overview:
- Parametrised system-identification and uptime peripheral on the Nios II Avalon-MM bus.
- Generalises the fixed two-word ID slave. Adds:
  - registered reads with readdatavalid
  - free-running uptime counter with atomic 64-bit snapshot
  - scratch, control and sticky status registers
  - NUM_USER parameter-defined read-only words
- Software uses it to confirm the hardware build and to timestamp events.

Parameters:
- SYSTEM_ID, 32'h5A7B_0001, value returned at word 0.
- TIMESTAMP, 32'd1518032159, build time returned at word 1.
- NUM_USER, 4, number of read-only user words (0..8).
- USER_VALUES, {NUM_USER{32'h0}}, packed user words; word k is bits [32k+31:32k].
- CNT_W, 64, uptime counter width (33..64); upper bits read as 0.
- ADDR_W, 4, word address width; 2^ADDR_W >= 8+NUM_USER, otherwise elaboration error.
- VERSION, 8'h02, block version reported in PARAM.

Ports:
- clock  input  1  sole clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  ADDR_W  Avalon word address.
- read  input  1  read strobe, one cycle per transfer.
- write  input  1  write strobe.
- writedata  input  32  write data.
- byteenable  input  4  byte lanes for writes.
- readdata  output  32  registered read data.
- readdatavalid  output  1  one-cycle pulse qualifying readdata.

Behaviour:
- Clock and reset:
  - One clock (clock).
  - Reset is asynchronous and active-low (reset_n): asserting it immediately forces all state to reset values; deassertion takes effect synchronously.
- Reset values:
  - readdata=0, readdatavalid=0
  - counter=0, hi_shadow=0, scratch=0
  - CONTROL=32'h1 (count enabled), STATUS=0
- Read timing:
  - Fixed latency 1. read at cycle N gives readdatavalid=1 and readdata=value at N+1.
  - No waitrequest. Back-to-back reads every cycle are supported.
  - readdata holds its last value when readdatavalid=0.
- Register map (word address):
  - 0 ID: RO, SYSTEM_ID.
  - 1 TIMESTAMP: RO, TIMESTAMP.
  - 2 UPTIME_LO: RO, counter[31:0]. The same read latches counter[CNT_W-1:32] (zero-extended) into hi_shadow, so the sampled 64-bit value is coherent.
  - 3 UPTIME_HI: RO, hi_shadow. Reading it does not change the shadow.
  - 4 SCRATCH: RW. Each byte is written only where its byteenable bit is 1.
  - 5 CONTROL: bit0 EN (RW); bit1 CLR (write 1 zeroes the counter next cycle, self-clearing, reads 0); other bits read 0.
  - 6 STATUS: bit0 OVF, sticky, write-1-to-clear; other bits read 0.
  - 7 PARAM: {8'h0, NUM_USER[7:0], ADDR_W[7:0], VERSION}.
  - 8..8+NUM_USER-1: USER words, RO.
  - All other addresses read 0; writes to them and to RO words are ignored.
- Counter:
  - Increments by 1 per cycle while EN=1 and wraps modulo 2^CNT_W.
  - On the wrap from all-ones to 0, OVF is set.
  - CLR and an increment in the same cycle: CLR wins (counter becomes 0, OVF not set by that cycle).
  - OVF set and OVF W1C in the same cycle: set wins.
- CONTROL/STATUS writes:
  - Applied only when byteenable[0]=1.
  - Writes to CONTROL/STATUS with byteenable[0]=0 are ignored.
- Same-cycle read and write:
  - Both are performed.
  - The read returns the pre-write value.
  - The UPTIME_LO latch uses the pre-increment counter value of that cycle.
- Reset mid-transfer: a read issued in the cycle reset asserts produces no readdatavalid.

Test Plan:
- Reset, then read words 0, 1, 7 back-to-back → readdatavalid on 3 consecutive cycles, data 32'h5A7B0001, 32'd1518032159, 32'h00040402.
- Read UPTIME_LO at cycle 100 after reset, then UPTIME_HI → LO=99 (counter counts from the first cycle after reset), HI=0. Force counter to 32'hFFFF_FFFF, read LO, let 10 cycles pass, read HI → HI=0; read LO again then HI → HI=1.
- CNT_W=33, counter preset to all-ones → next cycle counter=0 and STATUS=1. Write STATUS=1 in the wrap cycle → STATUS stays 1. Write again later → STATUS reads 0.
- Write SCRATCH=32'hDEADBEEF with be=4'hF, then 32'h00001200 with be=4'b0010 → reads 32'hDEAD12EF.
- Write CONTROL=0 → counter frozen over 50 cycles. Write CONTROL=3 → counter reads small value (cleared, then counting). CONTROL reads 1.
- NUM_USER=2, USER_VALUES={32'hB,32'hA} → word 8=32'hA, word 9=32'hB, words 10..15=0. Write to word 0 → ID unchanged. Assert reset_n low during a read → no readdatavalid, all registers at reset values.
